// File: rtl/uart_host_ctrl_pkg.sv
// uart_host_ctrl_pkg: register map, STATUS bit positions and FSM state types for the uart host controller.
package uart_host_ctrl_pkg;
  localparam logic [1:0] REG_DATA = 2'd0, REG_STATUS = 2'd1, REG_BAUD = 2'd2, REG_CTRL = 2'd3;
  localparam int ST_TX_FULL = 0, ST_TX_EMPTY = 1, ST_RX_NONEMPTY = 2, ST_RX_FULL = 3, ST_TX_BUSY = 4, ST_TX_OVF = 5;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_RELEASE} tx_state_t;
  typedef enum logic [1:0] {RX_WAIT, RX_CAPTURE, RX_CLEAR} rx_state_t;
endpackage

// File: rtl/uart_host_ctrl_if.sv
// uart_host_ctrl_if: MCU-side register bus; master is the CPU, slave is the controller.
interface uart_host_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input bus_rdata);
  modport slave (input bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/uart_host_ctrl_fifo.sv
// sync_fifo: single-clock FIFO; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: CPU-side register block for the uart core with TX/RX FIFOs and start_tx/rx_clear handshakes.
module uart_host_ctrl
  import uart_host_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [11:0] BAUD_DEFAULT = 12'd104
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_host_ctrl_if.slave      bus,
  output logic                 irq,
  output logic                 uart_start_tx,
  output logic [7:0]           uart_tx_value,
  input  logic                 uart_tx_done,
  input  logic                 uart_rx_available,
  input  logic [7:0]           uart_rx_value,
  output logic                 uart_rx_clear,
  output logic [11:0]          uart_counter_end
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;
  logic [11:0] baud;
  logic [1:0]  ctrl;
  logic        tx_ovf, tx_busy;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic        unused_cnt;
  logic        rd, wr, tx_push, tx_pop, rx_push, rx_pop;
  logic [31:0] status, rd_mux;
  assign unused_cnt = ^{tx_count, rx_count};
  assign rd      = bus.bus_sel & ~bus.bus_we;
  assign wr      = bus.bus_sel & bus.bus_we;
  assign tx_push = wr & (bus.bus_addr == REG_DATA);
  assign rx_pop  = rd & (bus.bus_addr == REG_DATA);
  assign tx_pop  = (tx_state == TX_START) & uart_tx_done;
  assign rx_push = rx_state == RX_CAPTURE;
  assign tx_busy = tx_state != TX_IDLE;
  assign uart_counter_end = baud;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.bus_wdata[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(uart_rx_value),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    status = '0;
    status[ST_TX_FULL]     = tx_full;
    status[ST_TX_EMPTY]    = tx_empty;
    status[ST_RX_NONEMPTY] = ~rx_empty;
    status[ST_RX_FULL]     = rx_full;
    status[ST_TX_BUSY]     = tx_busy;
    status[ST_TX_OVF]      = tx_ovf;
    rd_mux = (bus.bus_addr == REG_DATA)   ? {24'b0, rx_empty ? 8'h00 : rx_head} :
             (bus.bus_addr == REG_STATUS) ? status :
             (bus.bus_addr == REG_BAUD)   ? {20'b0, baud} : {30'b0, ctrl};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.bus_rdata <= '0;
      baud          <= BAUD_DEFAULT;
      ctrl          <= '0;
      tx_ovf        <= 1'b0;
      irq           <= 1'b0;
      tx_state      <= TX_IDLE;
      rx_state      <= RX_WAIT;
    end else begin
      if (rd) bus.bus_rdata <= rd_mux;
      if (wr && bus.bus_addr == REG_BAUD) baud <= bus.bus_wdata[11:0];
      if (wr && bus.bus_addr == REG_CTRL) ctrl <= bus.bus_wdata[1:0];
      tx_ovf   <= (tx_push & tx_full) |
                  (tx_ovf & ~(wr & (bus.bus_addr == REG_STATUS) & bus.bus_wdata[ST_TX_OVF]));
      irq      <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty & ~tx_busy);
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  // start_tx and tx_value come straight from state so an async reset drops them at once
  always_comb begin
    tx_next       = tx_state;
    rx_next       = rx_state;
    uart_start_tx = 1'b0;
    uart_tx_value = 8'h00;
    uart_rx_clear = 1'b0;
    case (tx_state)
      TX_IDLE:    tx_next = tx_empty ? TX_IDLE : TX_START;
      TX_START: begin
        uart_start_tx = 1'b1;
        uart_tx_value = tx_head;
        tx_next       = uart_tx_done ? TX_RELEASE : TX_START;
      end
      TX_RELEASE: tx_next = uart_tx_done ? TX_RELEASE : TX_IDLE;
      default:    tx_next = TX_IDLE;
    endcase
    case (rx_state)
      RX_WAIT:    rx_next = (uart_rx_available & ~rx_full) ? RX_CAPTURE : RX_WAIT;
      RX_CAPTURE: rx_next = RX_CLEAR;
      RX_CLEAR: begin
        uart_rx_clear = 1'b1;
        rx_next       = uart_rx_available ? RX_CLEAR : RX_WAIT;
      end
      default:    rx_next = RX_WAIT;
    endcase
  end
endmodule
